// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared branch funct3 codes, BHT counter type and helpers
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_ctr_t;

  // Saturating bimodal step: taken climbs toward ST, not-taken falls toward SNT.
  function automatic bht_ctr_t next_ctr(input bht_ctr_t ctr, input logic taken);
    bht_ctr_t n;
    n = ctr;
    case (ctr)
      SNT:     n = taken ? WNT : SNT;
      WNT:     n = taken ? WT  : SNT;
      WT:      n = taken ? ST  : WNT;
      ST:      n = taken ? ST  : WT;
      default: n = WNT;
    endcase
    return n;
  endfunction

  // funct3 010 and 011 are not branch encodings.
  function automatic logic is_legal_branch(input logic [2:0] f3);
    return (f3 != 3'b010) && (f3 != 3'b011);
  endfunction

  // Turns the comparator flags into a taken decision for a legal funct3.
  function automatic logic branch_taken(input logic [2:0] f3, input logic less,
                                        input logic equal);
    logic t;
    t = 1'b0;
    case (f3)
      F3_BEQ:            t = equal;
      F3_BNE:            t = ~equal;
      F3_BLT, F3_BLTU:   t = less;
      F3_BGE, F3_BGEU:   t = ~less;
      default:           t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/bht_2bit.sv
// rtl/bht_2bit.sv - 2-bit bimodal history table, async read, sync write
module bht_2bit
  import branch_pkg::*;
#(
  parameter int BHT_IDX_W = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BHT_IDX_W-1:0] rd_idx,
  output logic                 rd_taken,
  input  logic                 wr_en,
  input  logic [BHT_IDX_W-1:0] wr_idx,
  input  logic                 wr_taken
);

  localparam int DEPTH = 1 << BHT_IDX_W;

  bht_ctr_t tbl [DEPTH];

  // Read returns the stored value; a same-cycle write is not forwarded.
  assign rd_taken = tbl[rd_idx][1];

  // Every entry starts weakly not-taken; resolved branches step their entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl[i] <= WNT;
      end
    end else if (wr_en) begin
      tbl[wr_idx] <= next_ctr(tbl[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - branch resolution, BHT prediction, redirect and perf counters
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int BHT_IDX_W = 6,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      if_pc,
  output logic             if_pred_taken,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_is_jump,
  input  logic [2:0]       ex_funct3,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_target,
  input  logic             ex_pred_taken,
  input  logic             stall,
  input  logic             br_less,
  input  logic             br_equal,
  output logic             br_unsigned,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  logic        taken;
  logic        resolve;
  logic        br_resolve;
  logic        mispredict;
  logic        redirect_next;
  logic [31:0] redirect_tgt;

  // Only the index bits of the fetch PC select a BHT entry.
  logic if_pc_unused;
  assign if_pc_unused = &{1'b0, if_pc[31:BHT_IDX_W+2], if_pc[1:0]};

  // BLTU/BGEU are the funct3 codes with bit 1 set.
  assign br_unsigned = ex_funct3[1];

  // Resolve decision; anything in EX during a redirect pulse is wrong-path.
  always_comb begin
    taken         = branch_taken(ex_funct3, br_less, br_equal);
    resolve       = ex_valid & ~stall & ~redirect_valid;
    br_resolve    = resolve & ex_is_branch & ~ex_is_jump & is_legal_branch(ex_funct3);
    mispredict    = br_resolve & (taken != ex_pred_taken);
    redirect_next = (resolve & ex_is_jump) | mispredict;
    redirect_tgt  = (ex_is_jump | taken) ? ex_target : (ex_pc + 32'd4);
  end

  bht_2bit #(
    .BHT_IDX_W(BHT_IDX_W)
  ) u_bht (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_idx  (if_pc[BHT_IDX_W+1:2]),
    .rd_taken(if_pred_taken),
    .wr_en   (br_resolve),
    .wr_idx  (ex_pc[BHT_IDX_W+1:2]),
    .wr_taken(taken)
  );

  // One-cycle redirect pulse; the target is held between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
    end else begin
      redirect_valid <= redirect_next;
      if (redirect_next) begin
        redirect_pc <= redirect_tgt;
      end
    end
  end

  // Resolved-branch counter: clear wins over increment, saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count <= '0;
    end else if (cnt_clr) begin
      br_count <= '0;
    end else if (br_resolve && (br_count != {CNT_W{1'b1}})) begin
      br_count <= br_count + CNT_W'(1);
    end
  end

  // Mispredict counter: same clear priority and saturation as above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispred_count <= '0;
    end else if (cnt_clr) begin
      mispred_count <= '0;
    end else if (mispredict && (mispred_count != {CNT_W{1'b1}})) begin
      mispred_count <= mispred_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// tb/tb_branch_ctrl.sv - directed self-checking bench for branch_ctrl
module tb_branch_ctrl;
  import branch_pkg::*;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [31:0]      if_pc;
  logic             if_pred_taken;
  logic             ex_valid, ex_is_branch, ex_is_jump;
  logic [2:0]       ex_funct3;
  logic [31:0]      ex_pc, ex_target;
  logic             ex_pred_taken, stall, br_less, br_equal;
  logic             br_unsigned;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             cnt_clr;
  logic [CNT_W-1:0] br_count, mispred_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_ctrl #(.BHT_IDX_W(6), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
    .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .stall(stall), .br_less(br_less),
    .br_equal(br_equal), .br_unsigned(br_unsigned), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .cnt_clr(cnt_clr), .br_count(br_count),
    .mispred_count(mispred_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jump = 1'b0;
    ex_funct3 = 3'b000; ex_pc = 32'd0; ex_target = 32'd0;
    ex_pred_taken = 1'b0; br_less = 1'b0; br_equal = 1'b0;
    stall = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic drive_br(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] tgt,
                          input logic pred, input logic less, input logic equal);
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_is_jump = 1'b0;
    ex_funct3 = f3; ex_pc = pc; ex_target = tgt;
    ex_pred_taken = pred; br_less = less; br_equal = equal;
  endtask

  task automatic chk_cnt(input string tag, input int b, input int m);
    chk({tag, "_br"}, 32'(br_count), 32'(b));
    chk({tag, "_mis"}, 32'(mispred_count), 32'(m));
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    if_pc = 32'h100;
    #3;
    chk("rst_pred", 32'(if_pred_taken), 32'd0);
    chk("rst_rv", 32'(redirect_valid), 32'd0);
    chk("rst_rpc", redirect_pc, 32'd0);
    chk_cnt("rst", 0, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("idle_rv", 32'(redirect_valid), 32'd0);
    chk_cnt("idle", 0, 0);

    // BEQ taken, predicted not-taken -> redirect to target
    drive_br(F3_BEQ, 32'h100, 32'h140, 1'b0, 1'b0, 1'b1);
    chk("beq_uns", 32'(br_unsigned), 32'd0);
    tick();
    chk("beq_rv", 32'(redirect_valid), 32'd1);
    chk("beq_rpc", redirect_pc, 32'h140);
    chk_cnt("beq", 1, 1);
    chk("beq_bht", 32'(if_pred_taken), 32'd1);
    idle();
    tick();
    chk("beq_rv_once", 32'(redirect_valid), 32'd0);
    chk("beq_rpc_hold", redirect_pc, 32'h140);

    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk_cnt("clr", 0, 0);

    // BLTU not taken, predicted not-taken
    drive_br(F3_BLTU, 32'h200, 32'h900, 1'b0, 1'b0, 1'b0);
    chk("bltu_uns", 32'(br_unsigned), 32'd1);
    tick();
    chk("bltu_rv", 32'(redirect_valid), 32'd0);
    chk_cnt("bltu", 1, 0);

    // BGE not taken (less=1), predicted taken -> redirect to pc+4
    drive_br(F3_BGE, 32'h1FC, 32'h40, 1'b1, 1'b1, 1'b0);
    chk("bge_uns", 32'(br_unsigned), 32'd0);
    tick();
    chk("bge_rv", 32'(redirect_valid), 32'd1);
    chk("bge_rpc", redirect_pc, 32'h200);
    chk_cnt("bge", 2, 1);
    idle();
    tick();

    // BHT saturation at pc 0x304
    if_pc = 32'h304;
    for (int i = 0; i < 3; i++) begin
      drive_br(F3_BEQ, 32'h304, 32'h400, 1'b1, 1'b0, 1'b1);
      tick();
    end
    idle();
    chk("sat_hi_pred", 32'(if_pred_taken), 32'd1);
    drive_br(F3_BNE, 32'h304, 32'h400, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    chk("st_minus1_pred", 32'(if_pred_taken), 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive_br(F3_BEQ, 32'h304, 32'h400, 1'b0, 1'b0, 1'b0);
      tick();
    end
    idle();
    chk("sat_lo_pred", 32'(if_pred_taken), 32'd0);
    drive_br(F3_BLT, 32'h304, 32'h400, 1'b1, 1'b1, 1'b0);
    tick();
    idle();
    chk("snt_plus1_pred", 32'(if_pred_taken), 32'd0);
    chk_cnt("sat", 10, 1);

    // illegal funct3 codes have no effect
    drive_br(3'b010, 32'h304, 32'h400, 1'b0, 1'b0, 1'b1);
    tick();
    chk("ill010_rv", 32'(redirect_valid), 32'd0);
    drive_br(3'b011, 32'h304, 32'h400, 1'b1, 1'b0, 1'b0);
    tick();
    chk("ill011_rv", 32'(redirect_valid), 32'd0);
    chk_cnt("ill", 10, 1);

    // JAL (with is_branch also set) -> redirect, counters untouched
    drive_br(F3_BEQ, 32'h700, 32'h80, 1'b0, 1'b0, 1'b1);
    ex_is_jump = 1'b1;
    tick();
    chk("jal_rv", 32'(redirect_valid), 32'd1);
    chk("jal_rpc", redirect_pc, 32'h80);
    chk_cnt("jal", 10, 1);
    // shadow: mispredicting branch during redirect pulse is killed
    if_pc = 32'h608;
    drive_br(F3_BEQ, 32'h608, 32'h500, 1'b0, 1'b0, 1'b1);
    tick();
    chk("shadow_rv", 32'(redirect_valid), 32'd0);
    chk("shadow_rpc", redirect_pc, 32'h80);
    chk_cnt("shadow", 10, 1);
    chk("shadow_bht", 32'(if_pred_taken), 32'd0);

    // stall blocks resolution
    stall = 1'b1;
    tick();
    chk("stall_rv", 32'(redirect_valid), 32'd0);
    chk_cnt("stall", 10, 1);
    chk("stall_bht", 32'(if_pred_taken), 32'd0);
    idle();

    // counter saturation (CNT_W=4 -> 15)
    for (int i = 0; i < 16; i++) begin
      drive_br(F3_BEQ, 32'h608, 32'h500, 1'b0, 1'b0, 1'b1);
      tick();
      idle();
      tick();
    end
    chk_cnt("cnt_sat", 15, 15);
    chk("cnt_sat_bht", 32'(if_pred_taken), 32'd1);

    // clear beats increment
    drive_br(F3_BEQ, 32'h608, 32'h500, 1'b0, 1'b0, 1'b1);
    cnt_clr = 1'b1;
    tick();
    chk_cnt("clr_inc", 0, 0);
    chk("clr_inc_rv", 32'(redirect_valid), 32'd1);
    chk("clr_inc_rpc", redirect_pc, 32'h500);
    idle();
    tick();

    // reset mid-operation drops pending redirect and restores BHT
    drive_br(F3_BEQ, 32'h608, 32'h600, 1'b0, 1'b0, 1'b1);
    tick();
    chk("pre_rst_rv", 32'(redirect_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rv", 32'(redirect_valid), 32'd0);
    chk("mid_rst_rpc", redirect_pc, 32'd0);
    chk("mid_rst_bht", 32'(if_pred_taken), 32'd0);
    chk_cnt("mid_rst", 0, 0);
    idle();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_rv", 32'(redirect_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
Branch resolution and prediction controller for the pipelined RV32I core. It sequences the branch comparator in EX, driving its signedness select from funct3 and turning its less/equal flags into a taken decision. It keeps a 2-bit bimodal branch history table (BHT) that the IF stage looks up, and issues a registered redirect/flush on mispredicts and jumps. It also maintains saturating branch and mispredict performance counters.

Parameters:
BHT_IDX_W, 6, log2 of BHT entries; index = pc[BHT_IDX_W+1:2]
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  core clock
rst_n  in  1  reset, asynchronous, active-low
if_pc  in  32  fetch PC for BHT lookup
if_pred_taken  out  1  BHT prediction for if_pc (counter MSB)
ex_valid  in  1  EX stage holds a real instruction
ex_is_branch  in  1  conditional branch in EX
ex_is_jump  in  1  JAL/JALR in EX
ex_funct3  in  3  branch funct3
ex_pc  in  32  PC of EX instruction
ex_target  in  32  computed branch/jump target
ex_pred_taken  in  1  prediction carried down from IF
stall  in  1  EX frozen this cycle
br_less  in  1  from comparator
br_equal  in  1  from comparator
br_unsigned  out  1  to comparator
redirect_valid  out  1  one-cycle redirect/flush pulse
redirect_pc  out  32  PC to fetch on redirect
cnt_clr  in  1  synchronous clear of performance counters
br_count  out  CNT_W  resolved conditional branches
mispred_count  out  CNT_W  mispredicted conditional branches

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: redirect_valid=0, redirect_pc=0, br_count=0, mispred_count=0, all BHT entries=01 (weakly not-taken).
- br_unsigned = ex_funct3[1]; purely combinational, independent of valid.
- taken decode:
  - 000 BEQ: equal.
  - 001 BNE: !equal.
  - 100 BLT / 110 BLTU: less.
  - 101 BGE / 111 BGEU: !less.
  - 010 and 011: illegal; not taken, no BHT update, no count.
- resolve = ex_valid & !stall & !redirect_valid. The shadow kill: an instruction in EX while redirect_valid=1 is wrong-path. It has no effect on the BHT, the counters or redirect.
- On resolve with a legal branch:
  - br_count increments.
  - The BHT entry at ex_pc index updates. Taken moves the counter up, not-taken moves it down, saturating at 00 and 11.
  - If taken != ex_pred_taken: mispred_count increments and a redirect is scheduled.
  - Redirect target is ex_target if taken, else ex_pc+4 (32-bit wrap).
- On resolve with ex_is_jump: a redirect to ex_target is always scheduled. BHT and counters are untouched. ex_is_branch and ex_is_jump together: jump wins.
- Redirect latency:
  - redirect_valid and redirect_pc are registered and asserted the cycle after resolve, for exactly one cycle.
  - Next cycle redirect_valid=0 unless a new resolve (impossible under shadow kill).
  - redirect_pc holds its last value when redirect_valid=0.
- BHT read:
  - if_pred_taken is combinational from the stored array.
  - On a same-index update in the same cycle, the read returns the pre-update value (no bypass).
- Counters:
  - Saturate at all-ones.
  - cnt_clr has priority over an increment in the same cycle; the result is 0.
- Stall: no resolution, no updates. A redirect already registered still pulses.
- Reset mid-operation: a pending redirect is dropped; the BHT returns to 01 everywhere.

Decomposition:
- Package branch_pkg:
  - funct3 constants F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU.
  - 2-bit counter typedef bht_ctr_t with SNT=00, WNT=01, WT=10, ST=11.
  - Function next_ctr(ctr, taken).
- Sub-module bht_2bit:
  - Array plus async reset.
  - Combinational read port, synchronous write port, parameterised by BHT_IDX_W.

Test Plan:
- Reset, then if_pc=0x100 → if_pred_taken=0. Release reset with all inputs idle → redirect_valid stays 0 and counters stay 0.
- BEQ at ex_pc=0x100, br_equal=1, ex_pred_taken=0, ex_target=0x140 → next cycle redirect_valid=1 with redirect_pc=0x140, for one cycle only. br_count=1, mispred_count=1, and the BHT[0x100] lookup returns 1.
- BLTU at ex_pc=0x200 with br_unsigned expected 1, br_less=0, ex_pred_taken=0 → no redirect, br_count=1, mispred_count=0. Then BGE at ex_pc=0x1FC with br_less=1 and pred 1 → redirect_pc=0x200.
- Three taken resolves at the same PC → counter saturates at 11. Four not-taken resolves then give 00, and if_pred_taken=0.
- JAL with ex_target=0x80 → redirect_pc=0x80 and counters unchanged. In the redirect cycle, ex_valid=1 with a mispredicting branch → no second redirect and no counts.
- stall=1 with a mispredicting branch → no redirect. Preload both counters to the all-ones value via a forced count, then resolve again → values stay saturated. cnt_clr together with an increment → both counters 0.
